// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the serial adder.
// The master drives the operation, the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CarryIN;
    logic             Sub;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             CarryOUT;
    logic             Overflow;

    modport master (
        output Start, A, B, CarryIN, Sub,
        input  Busy, Done, Sum, CarryOUT, Overflow
    );

    modport slave (
        input  Start, A, B, CarryIN, Sub,
        output Busy, Done, Sum, CarryOUT, Overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock.
// Result, carry/borrow and overflow are held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic          Clk,
    input logic          Reset_n,
    serial_adder_if.slave bus
);
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DIGIT + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DW-1:0]    dsum;
    logic [WIDTH-1:0] res_nx;

    // Next-state, digit datapath and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        dsum   = {1'b0, a_q[DIGIT-1:0]}
               + {1'b0, b_q[DIGIT-1:0]}
               + DW'(c_q);
        res_nx = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.Start) begin
                    state_d = S_RUN;
                    a_d     = bus.A;
                    b_d     = bus.Sub ? ~bus.B : bus.B;
                    c_d     = bus.Sub ^ bus.CarryIN;
                    sub_d   = bus.Sub;
                    amsb_d  = bus.A[WIDTH-1];
                    bmsb_d  = bus.Sub ^ bus.B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = dsum[DIGIT];
                res_d = res_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    sum_d   = res_nx;
                    cout_d  = sub_q ^ dsum[DIGIT];
                    ovf_d   = (amsb_q == bmsb_q)
                           && (res_nx[WIDTH-1] != amsb_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Busy     = (state_q == S_RUN);
    assign bus.Done     = (state_q == S_DONE);
    assign bus.Sum      = sum_q;
    assign bus.CarryOUT = cout_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder
// for (8,1), (8,4) and (1,1) against an arithmetic reference.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // shared 8-bit stimulus, routed to one of the two 8-bit DUTs
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_r = '0;
    logic [7:0] b_r = '0;
    logic       cin_r = 1'b0;
    logic       sub_r = 1'b0;

    logic       start1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       sub1 = 1'b0;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(8)) if84 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    assign if8.Start    = start & ~sel;
    assign if8.A        = a_r;
    assign if8.B        = b_r;
    assign if8.CarryIN  = cin_r;
    assign if8.Sub      = sub_r;
    assign if84.Start   = start & sel;
    assign if84.A       = a_r;
    assign if84.B       = b_r;
    assign if84.CarryIN = cin_r;
    assign if84.Sub     = sub_r;
    assign if1.Start    = start1;
    assign if1.A        = a1;
    assign if1.B        = b1;
    assign if1.CarryIN  = cin1;
    assign if1.Sub      = sub1;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .Clk(clk), .Reset_n(rst_n), .bus(if8)
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .Clk(clk), .Reset_n(rst_n), .bus(if84)
    );
    serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .Clk(clk), .Reset_n(rst_n), .bus(if1)
    );

    logic       busy_m, done_m, cout_m, ovf_m;
    logic [7:0] sum_m;
    assign busy_m = sel ? if84.Busy : if8.Busy;
    assign done_m = sel ? if84.Done : if8.Done;
    assign sum_m  = sel ? if84.Sum : if8.Sum;
    assign cout_m = sel ? if84.CarryOUT : if8.CarryOUT;
    assign ovf_m  = sel ? if84.Overflow : if8.Overflow;

    // last completed result per 8-bit DUT (index = sel) and for WIDTH=1
    int psum[2], pco[2], pov[2];
    int psum1, pco1, pov1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // plain-integer reference: modular result, carry/borrow, signed range
    function automatic void model(input int w, input int a, input int b,
                                  input int cin, input int sub,
                                  output int s, output int co,
                                  output int ov);
        int mask, sa, sb, full, r;
        mask = (1 << w) - 1;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        if (sub != 0) begin
            full = a - b - cin;
            co   = (full < 0) ? 1 : 0;
            r    = sa - sb - cin;
        end else begin
            full = a + b + cin;
            co   = (full > mask) ? 1 : 0;
            r    = sa + sb + cin;
        end
        s  = full & mask;
        ov = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
    endfunction

    // one 8-bit operation; entered and left just after a rising edge
    task automatic op8(input bit use4, input int a, input int b,
                       input int cin, input int sub,
                       input bit hold, input bit poke);
        int n, es, ec, eo, k;
        k = use4 ? 1 : 0;
        n = use4 ? 2 : 8;
        model(8, a, b, cin, sub, es, ec, eo);
        sel   = use4;
        a_r   = a[7:0];
        b_r   = b[7:0];
        cin_r = cin[0];
        sub_r = sub[0];
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            chk("busy", busy_m, 1);
            chk("done_in_run", done_m, 0);
            chk("sum_hold", sum_m, psum[k]);
            chk("cout_hold", cout_m, pco[k]);
            chk("ovf_hold", ovf_m, pov[k]);
            if (hold || poke) begin
                a_r   = $urandom;
                b_r   = $urandom;
                cin_r = $urandom_range(0, 1);
                sub_r = $urandom_range(0, 1);
            end
            if (poke) start = (i == 1);
            @(posedge clk); #1;
        end
        chk("done", done_m, 1);
        chk("busy_at_done", busy_m, 0);
        chk("sum", sum_m, es);
        chk("cout", cout_m, ec);
        chk("ovf", ovf_m, eo);
        psum[k] = es;
        pco[k]  = ec;
        pov[k]  = eo;
    endtask

    task automatic idle8();
        @(posedge clk); #1;
        chk("done_once", done_m, 0);
        chk("busy_idle", busy_m, 0);
    endtask

    task automatic op1(input int a, input int b, input int cin,
                       input int sub);
        int es, ec, eo;
        model(1, a, b, cin, sub, es, ec, eo);
        a1 = a[0]; b1 = b[0]; cin1 = cin[0]; sub1 = sub[0];
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("w1_busy", if1.Busy, 1);
        chk("w1_done_in_run", if1.Done, 0);
        chk("w1_sum_hold", if1.Sum, psum1);
        @(posedge clk); #1;
        chk("w1_done", if1.Done, 1);
        chk("w1_sum", if1.Sum, es);
        chk("w1_cout", if1.CarryOUT, ec);
        chk("w1_ovf", if1.Overflow, eo);
        psum1 = es; pco1 = ec; pov1 = eo;
        @(posedge clk); #1;
        chk("w1_done_once", if1.Done, 0);
        chk("w1_busy_idle", if1.Busy, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            psum[k] = 0; pco[k] = 0; pov[k] = 0;
        end
        psum1 = 0; pco1 = 0; pov1 = 0;

        // reset state
        #12;
        chk("rst_busy8", if8.Busy, 0);
        chk("rst_done8", if8.Done, 0);
        chk("rst_sum8", if8.Sum, 0);
        chk("rst_cout84", if84.CarryOUT, 0);
        chk("rst_ovf1", if1.Overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases from the plan
        op8(0, 'h5A, 'h3C, 0, 0, 0, 0);
        idle8();
        op8(0, 'hFF, 'h01, 1, 0, 0, 0);
        idle8();
        op8(1, 'h10, 'h20, 0, 1, 0, 0);
        idle8();
        op8(1, 'h80, 'h01, 0, 1, 0, 0);
        idle8();

        // exhaustive full adder plus a few subtracts
        for (int i = 0; i < 8; i++) op1(i & 1, (i >> 1) & 1, (i >> 2) & 1, 0);
        for (int i = 0; i < 4; i++) op1(i & 1, (i >> 1) & 1, 1, 1);

        // random ops, mixed DUTs, some with Start pokes during Busy
        for (int i = 0; i < 16; i++) begin
            op8(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), 0,
                bit'($urandom_range(0, 1)));
        end
        idle8();

        // Start held high: back-to-back every N+1 cycles
        for (int i = 0; i < 6; i++)
            op8(0, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                1, 0);
        start = 1'b0;
        idle8();
        for (int i = 0; i < 6; i++)
            op8(1, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                1, 0);
        start = 1'b0;
        idle8();

        // reset in RUN cycle 4 of an 8-cycle add
        op8(0, 'h5A, 'h3C, 0, 0, 0, 0);
        idle8();
        sel = 1'b0;
        a_r = 8'h33; b_r = 8'h44; cin_r = 1'b0; sub_r = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", busy_m, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_done", done_m, 0);
        chk("mid_rst_sum", sum_m, 0);
        chk("mid_rst_cout", cout_m, 0);
        chk("mid_rst_ovf", ovf_m, 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            psum[k] = 0; pco[k] = 0; pov[k] = 0;
        end
        psum1 = 0; pco1 = 0; pov1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", done_m, 0);
            chk("no_busy_after_rst", busy_m, 0);
        end

        // recovery
        op8(0, 'hC8, 'h64, 1, 1, 0, 0);
        idle8();
        op8(1, 'h7F, 'h01, 0, 0, 0, 0);
        idle8();
        op1(1, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
